// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Tracks in-flight register writers behind ID and decides, every cycle,
//   whether the instruction in ID must stall, whether IF/ID must be flushed
//   after a redirect, and (optionally) from which stage each source operand
//   should be forwarded.
//
//   Build option: define HAZARD_FORWARDING_EN to enable operand forwarding.
//   Without it fwd_*_sel are tied to 0 and ID waits for the producer to reach
//   WB (the register file is write-through, so WB is visible to ID).
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_rs/id_rt           source register addresses
//   id_uses_rs/id_uses_rt source actually read
//   id_reg_write          ID instruction writes id_dest
//   id_mem_read           ID instruction is a load
//   id_dest               ID destination register
//   redirect              taken branch/jump resolved this cycle
//   stall                 hold PC and IF/ID, bubble into EX
//   flush                 squash IF/ID
//   fwd_rs_sel/fwd_rt_sel 0 = register file, k+1 = result of scoreboard entry k
//   stall_count           saturating count of stall cycles

module pipeline_hazard_unit #(
    parameter int DEPTH        = 3,  // entry 0 = EX ... entry DEPTH-1 = WB
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int SEL_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_dest,
    input  logic             redirect,
    output logic             stall,
    output logic             flush,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic [15:0]      stall_count
);

    localparam int CNT_W = 3;  // holds FLUSH_CYCLES up to 7

    typedef struct packed {
        logic             valid;
        logic             regWrite;
        logic             memRead;
        logic [REG_W-1:0] dest;
    } sbEntry_t;

    sbEntry_t [DEPTH-1:0] sb;
    logic [CNT_W-1:0]     flushCnt;
    logic [DEPTH-1:0]     rsMatch;
    logic [DEPTH-1:0]     rtMatch;
    logic                 hazard;

    // The retiring entry's load flag is never consulted.
    logic unusedRetireMemRead;
    assign unusedRetireMemRead = sb[DEPTH-1].memRead;

    // Per-entry source compare; register 0 never matches.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : gMatch
            assign rsMatch[k] = sb[k].valid && sb[k].regWrite && id_uses_rs &&
                                (id_rs != '0) && (sb[k].dest == id_rs);
            assign rtMatch[k] = sb[k].valid && sb[k].regWrite && id_uses_rt &&
                                (id_rt != '0) && (sb[k].dest == id_rt);
        end
    endgenerate

    assign flush = (flushCnt != '0);
    // Flush wins over stall: the instruction in ID is being squashed anyway.
    assign stall = id_valid && !flush && hazard;

`ifdef HAZARD_FORWARDING_EN
    logic             rsHit, rtHit;
    logic [SEL_W-1:0] rsIdx, rtIdx;

    // Scan oldest to youngest so the lowest matching entry wins.
    always_comb begin
        rsHit = 1'b0;
        rtHit = 1'b0;
        rsIdx = '0;
        rtIdx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rsMatch[k]) begin
                rsHit = 1'b1;
                rsIdx = SEL_W'(k);
            end
            if (rtMatch[k]) begin
                rtHit = 1'b1;
                rtIdx = SEL_W'(k);
            end
        end
    end

    // Only a load still in EX cannot be forwarded: its data arrives a stage late.
    assign hazard = (rsHit && (rsIdx == '0) && sb[0].memRead) ||
                    (rtHit && (rtIdx == '0) && sb[0].memRead);

    assign fwd_rs_sel = (stall || flush || !rsHit) ? '0 : rsIdx + SEL_W'(1);
    assign fwd_rt_sel = (stall || flush || !rtHit) ? '0 : rtIdx + SEL_W'(1);
`else
    // No bypass network: wait until the producer reaches WB.
    assign hazard     = (|rsMatch[DEPTH-2:0]) || (|rtMatch[DEPTH-2:0]);
    assign fwd_rs_sel = '0;
    assign fwd_rt_sel = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb          <= '0;
            flushCnt    <= '0;
            stall_count <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb[k] <= sb[k-1];
            end
            if (id_valid && !stall && !flush) begin
                sb[0] <= {1'b1, id_reg_write, id_mem_read, id_dest};
            end else begin
                sb[0] <= '0;
            end

            // A redirect restarts the window rather than extending it.
            if (redirect) begin
                flushCnt <= CNT_W'(FLUSH_CYCLES);
            end else if (flushCnt != '0) begin
                flushCnt <= flushCnt - 1'b1;
            end

            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, redirect;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       stall, flush;
    logic [2:0] fwd_rs_sel, fwd_rt_sel;
    logic [15:0] stall_count;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_dest(id_dest),
        .redirect(redirect),
        .stall(stall), .flush(flush),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [2:0]  fwdRs;
        logic [2:0]  fwdRt;
        logic [15:0] cnt;
        bit          chkFwd;
        string       tag;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nErrors = 0;
    int   expCnt  = 0;  // stall cycles expected so far

    task automatic pushExp(input string tag, input logic st, input logic fl,
                           input logic [2:0] fr, input logic [2:0] ft, input bit cf);
        exp_t e;
        e.stall = st; e.flush = fl; e.fwdRs = fr; e.fwdRt = ft;
        e.cnt = 16'(expCnt); e.chkFwd = cf; e.tag = tag;
        expQ.push_back(e);
        if (st) expCnt++;
    endtask

    task automatic checkOut();
        exp_t e;
        nChecks++;
        assert (expQ.size() != 0) else begin
            nErrors++;
            $error("FAIL queue: got empty, expected an entry");
            return;
        end
        e = expQ.pop_front();
        nChecks++;
        assert (stall === e.stall) else begin
            nErrors++; $error("FAIL %s stall: got %0d expected %0d", e.tag, stall, e.stall);
        end
        nChecks++;
        assert (flush === e.flush) else begin
            nErrors++; $error("FAIL %s flush: got %0d expected %0d", e.tag, flush, e.flush);
        end
        nChecks++;
        assert (stall_count === e.cnt) else begin
            nErrors++; $error("FAIL %s stall_count: got %0d expected %0d", e.tag, stall_count, e.cnt);
        end
        if (e.chkFwd) begin
            nChecks++;
            assert (fwd_rs_sel === e.fwdRs) else begin
                nErrors++; $error("FAIL %s fwd_rs_sel: got %0d expected %0d", e.tag, fwd_rs_sel, e.fwdRs);
            end
            nChecks++;
            assert (fwd_rt_sel === e.fwdRt) else begin
                nErrors++; $error("FAIL %s fwd_rt_sel: got %0d expected %0d", e.tag, fwd_rt_sel, e.fwdRt);
            end
        end
    endtask

    // One ID cycle: drive at the falling edge, check combinational outputs 1ns later.
    task automatic cyc(input string tag, input logic v,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic rw, input logic mr, input logic [4:0] dst, input logic rd,
                       input logic st, input logic fl, input logic [2:0] fr, input logic [2:0] ft,
                       input bit cf);
        @(negedge clk);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_reg_write = rw; id_mem_read = mr; id_dest = dst; redirect = rd;
        pushExp(tag, st, fl, fr, ft, cf);
        #1 checkOut();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_reg_write = 0; id_mem_read = 0; id_dest = 0; redirect = 0;
        #2;
        pushExp("reset", 0, 0, 0, 0, 1);
        checkOut();
        @(negedge clk);
        reset = 1'b1;

        if (FWD) begin
            //           tag        v  rs urs rt urt rw mr dst rd  st fl fr ft cf
            cyc("f_add8",   1, 0, 0, 0, 0, 1, 0, 8, 0,  0, 0, 0, 0, 1);
            cyc("f_ex",     1, 8, 1, 0, 0, 1, 0, 20, 0, 0, 0, 1, 0, 1);
            cyc("f_mem",    1, 8, 1, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 1);
            cyc("f_lw9",    1, 0, 0, 0, 0, 1, 1, 9, 0,  0, 0, 0, 0, 1);
            cyc("f_lu",     1, 0, 0, 9, 1, 1, 0, 21, 0, 1, 0, 0, 0, 1);
            cyc("f_lu2",    1, 0, 0, 9, 1, 1, 0, 21, 0, 0, 0, 0, 2, 1);
            cyc("f_p22a",   1, 0, 0, 0, 0, 1, 0, 22, 0, 0, 0, 0, 0, 1);
            cyc("f_p22b",   1, 21, 1, 0, 0, 1, 0, 22, 0, 0, 0, 2, 0, 1);
            cyc("f_young",  1, 22, 1, 22, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        end else begin
            cyc("n_add10",  1, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0, 0, 0, 1);
            cyc("n_dep1",   1, 10, 1, 0, 0, 1, 0, 11, 0, 1, 0, 0, 0, 1);
            cyc("n_dep2",   1, 10, 1, 0, 0, 1, 0, 11, 0, 1, 0, 0, 0, 1);
            cyc("n_go",     1, 10, 1, 0, 0, 1, 0, 11, 0, 0, 0, 0, 0, 1);
        end

        // Drain the scoreboard.
        for (int i = 0; i < 3; i++)
            cyc("c_drain",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

        cyc("c_p15",        1, 0, 0, 0, 0, 1, 0, 15, 0, 0, 0, 0, 0, 1);
        cyc("c_novld",      0, 15, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("c_w0",         1, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        cyc("c_r0",         1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        cyc("c_p12",        1, 0, 0, 0, 0, 1, 0, 12, 0, 0, 0, 0, 0, 1);
        cyc("c_nouse",      1, 12, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("c_rt12",       1, 0, 0, 12, 1, 0, 0, 0, 0, !FWD, 0, 0, FWD ? 3'd2 : 3'd0, 1);
        cyc("c_p14",        1, 0, 0, 0, 0, 1, 0, 14, 0, 0, 0, 0, 0, 1);

        // Overlapping redirects: window reloads, hazard masked while flushing.
        cyc("c_redir",      0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        cyc("c_flush1",     1, 14, 1, 0, 0, 1, 0, 13, 0, 0, 1, 0, 0, 1);
        cyc("c_flush2",     1, 13, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        cyc("c_flush3",     1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("c_flush4",     1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("c_flush_end",  1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Single redirect pulse: exactly FLUSH_CYCLES flush cycles.
        cyc("c_pulse",      0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);
        cyc("c_pulse1",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc("c_pulse2",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc("c_pulse3",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of a load-use stall.
        cyc("r_lw9",        1, 0, 0, 0, 0, 1, 1, 9, 0,  0, 0, 0, 0, 1);
        cyc("r_stall",      1, 0, 0, 9, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1);
        #1 reset = 1'b0;
        expCnt = 0;
        #1;
        pushExp("r_async", 0, 0, 0, 0, 1);
        checkOut();
        @(negedge clk);
        reset = 1'b1;
        cyc("r_after",      1, 0, 0, 9, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        cyc("r_after2",     1, 0, 0, 9, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3: number of tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB); legal range 2..6.
REQ-002 Parameter REG_W, default 5: register address width.
REQ-003 Parameter FLUSH_CYCLES, default 2: bubbles injected after a redirect; legal range 1..7.
REQ-004 Parameter SEL_W, default 3: forward-select width; SHALL satisfy 2^SEL_W > DEPTH.
REQ-005 Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_W  ID source register addresses.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_reg_write  in  1  ID instruction writes a register.
- id_mem_read  in  1  ID instruction is a load.
- id_dest  in  REG_W  ID destination register.
- redirect  in  1  taken branch/jump resolved this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  squash IF/ID contents.
- fwd_rs_sel, fwd_rt_sel  out  SEL_W  0 = register file, k+1 = result of entry k.
- stall_count  out  16  saturating count of stall cycles.

Function
REQ-006 Scoreboard SHALL hold DEPTH entries {valid, reg_write, mem_read, dest}; every cycle all entries shift one position toward WB; entry DEPTH-1 retires.
REQ-007 Entry 0 SHALL load the ID fields when id_valid=1, stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-008 Source s SHALL match entry k when valid=1, reg_write=1, dest==s, s!=0, and the corresponding id_uses bit is 1.
REQ-009 Register 0 SHALL never match, never stall, never forward.
REQ-010 stall SHALL be combinational from current ID inputs and scoreboard; stall SHALL be 0 when id_valid=0.
REQ-011 When several entries match, the lowest k (youngest producer) SHALL determine forwarding and stall.
REQ-012 redirect=1 SHALL load a flush counter with FLUSH_CYCLES on the next edge; flush SHALL be 1 while counter!=0; counter decrements by 1 per cycle.
REQ-013 redirect while counter!=0 SHALL reload FLUSH_CYCLES (no accumulation).
REQ-014 While flush=1, stall SHALL be 0 (flush has priority).
REQ-015 stall_count SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.
REQ-016 Outputs fwd_*_sel SHALL be 0 whenever stall=1 or flush=1.

Reset
REQ-017 reset=0 SHALL immediately clear all scoreboard valid bits, the flush counter and stall_count, and drive stall=0, flush=0, fwd_rs_sel=0, fwd_rt_sel=0.
REQ-018 Reset asserted mid-stall or mid-flush SHALL abandon the operation; first cycle after release behaves as an empty pipeline.

Configuration
REQ-019 Macro HAZARD_FORWARDING_EN defined: stall only when the youngest match is entry 0 with mem_read=1 (load-use, exactly one stall cycle); otherwise fwd_sel = k+1 of the youngest match.
REQ-020 HAZARD_FORWARDING_EN undefined: fwd_*_sel SHALL be constant 0; stall SHALL be 1 while any match exists in entries 0..DEPTH-2 (WB write is visible to ID in the same cycle).

Verification
REQ-021 Defaults, forwarding on: add $8 in EX, ID add reads $8 -> stall=0, fwd_rs_sel=1; next cycle $8 in entry 1 with new reader -> fwd_rs_sel=2.
REQ-022 Forwarding on: lw $9 in EX, ID reads $9 as rt -> stall=1 for exactly one cycle, then fwd_rt_sel=2, stall_count=1.
REQ-023 Forwarding off: add $10 issued, dependent ID reader -> stall=1 for 2 cycles (DEPTH-1), then proceeds with fwd sel 0, stall_count=2.
REQ-024 redirect pulse at cycle T -> flush=1 at T+1 and T+2, 0 at T+3; second redirect at T+2 -> flush held through T+4.
REQ-025 ID writes/reads $0 behind producer of $0 -> stall=0, fwd sel 0.
REQ-026 reset=0 asserted asynchronously mid load-use stall -> stall=0, stall_count=0 before next edge; after release dependent reader sees no hazard.
